// File: rtl/stack_pkg.sv
// Shared types and constants for the stack core flit merge points and link serializers.
package stack_pkg;

   localparam int FLIT_W   = 11;
   localparam int TAIL_BIT = FLIT_W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TOP  = 2'd1,
      BOT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/stack_flit_reg.sv
// Single-entry valid/ready output register; can_load_o says the slot may take a new flit this cycle.
module stack_flit_reg #(
   parameter int W = stack_pkg::FLIT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         can_load_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   assign can_load_o = !valid_q || ready_i;
   assign valid_o    = valid_q;
   assign data_o     = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/stack_flit_arbiter.sv
// Packet-granular round-robin merge of the top and bottom link flit streams toward BD.
// Optional per-input packet counters are built when STACK_ARB_COUNT_EN is defined.
//
// state | meaning
// IDLE  | no owner; pick next owner from valids and last served input
// TOP   | top link owns the output until its tail flit is accepted
// BOT   | bottom link owns the output until its tail flit is accepted
module stack_flit_arbiter #(
   parameter int FLIT_W = stack_pkg::FLIT_W
`ifdef STACK_ARB_COUNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] top_data,
   input  logic              top_valid,
   output logic              top_ready,
   input  logic [FLIT_W-1:0] bot_data,
   input  logic              bot_valid,
   output logic              bot_ready,
   output logic [FLIT_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        grant
`ifdef STACK_ARB_COUNT_EN
   ,
   output logic [CNT_W-1:0]  top_pkt_count,
   output logic [CNT_W-1:0]  bot_pkt_count
`endif
);
   import stack_pkg::*;

   localparam int TAIL = FLIT_W - 1;

   arb_state_e        state_q, state_d;
   arb_state_e        last_q, last_d;
   logic              can_load;
   logic              sel_valid;
   logic [FLIT_W-1:0] sel_data;
   logic              accept;
   logic              pkt_done;

   assign sel_data  = (state_q == BOT) ? bot_data : top_data;
   assign sel_valid = (state_q == TOP) ? top_valid :
                      (state_q == BOT) ? bot_valid : 1'b0;
   assign accept    = sel_valid && can_load;
   assign pkt_done  = accept && sel_data[TAIL];

   assign top_ready = (state_q == TOP) && can_load;
   assign bot_ready = (state_q == BOT) && can_load;
   assign grant     = {state_q == BOT, state_q == TOP};

   // Ties go to whichever input was not served last; last resets to BOT so top wins first.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (top_valid && (!bot_valid || last_q == BOT)) begin
               state_d = TOP;
            end else if (bot_valid) begin
               state_d = BOT;
            end
         end
         TOP, BOT: begin
            if (pkt_done) begin
               state_d = IDLE;
               last_d  = state_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= BOT;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   stack_flit_reg #(
      .W (FLIT_W)
   ) u_out_reg (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (accept),
      .data_i     (sel_data),
      .ready_i    (out_ready),
      .valid_o    (out_valid),
      .data_o     (out_data),
      .can_load_o (can_load)
   );

`ifdef STACK_ARB_COUNT_EN
   logic [CNT_W-1:0] top_cnt_q, top_cnt_d;
   logic [CNT_W-1:0] bot_cnt_q, bot_cnt_d;

   always_comb begin
      top_cnt_d = top_cnt_q;
      bot_cnt_d = bot_cnt_q;
      if (pkt_done && state_q == TOP) begin
         top_cnt_d = top_cnt_q + CNT_W'(1);
      end
      if (pkt_done && state_q == BOT) begin
         bot_cnt_d = bot_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         top_cnt_q <= '0;
         bot_cnt_q <= '0;
      end else begin
         top_cnt_q <= top_cnt_d;
         bot_cnt_q <= bot_cnt_d;
      end
   end

   assign top_pkt_count = top_cnt_q;
   assign bot_pkt_count = bot_cnt_q;
`endif

endmodule

// File: tb/tb_stack_flit_arbiter.sv
// Bench for stack_flit_arbiter: directed packet scenarios plus random traffic against a packet-level model.
module tb_stack_flit_arbiter;
   localparam int FW = 11;
`ifdef STACK_ARB_COUNT_EN
   localparam int CW = 4;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [FW-1:0] top_data = '0, bot_data = '0;
   logic          top_valid = 1'b0, bot_valid = 1'b0;
   logic          top_ready, bot_ready;
   logic [FW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [1:0]    grant;
`ifdef STACK_ARB_COUNT_EN
   logic [CW-1:0] top_pkt_count, bot_pkt_count;
`endif

   stack_flit_arbiter #(
      .FLIT_W (FW)
`ifdef STACK_ARB_COUNT_EN
      ,
      .CNT_W  (CW)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .top_data  (top_data),
      .top_valid (top_valid),
      .top_ready (top_ready),
      .bot_data  (bot_data),
      .bot_valid (bot_valid),
      .bot_ready (bot_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant)
`ifdef STACK_ARB_COUNT_EN
      ,
      .top_pkt_count (top_pkt_count),
      .bot_pkt_count (bot_pkt_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [FW-1:0] top_src[$];
   logic [FW-1:0] bot_src[$];
   logic [FW-1:0] exp_q[$];
   logic [1:0]    glog[$];
   logic [1:0]    gexp [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};

   // Model: owner 0 = none, 1 = top, 2 = bottom; output slot holds m_od while m_ov.
   int            m_owner, m_last, m_tc, m_bc;
   bit            m_ov;
   logic [FW-1:0] m_od;
   bit            t_take, b_take;
   bit            running = 1'b0;
   bit            log_en = 1'b0;
   int            top_p = 100, bot_p = 100, ord_p = 100, stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : model
      logic [1:0]    eg;
      bit            can, etr, ebr, ta, ba;
      int            start_owner;
      logic [FW-1:0] f;
      if (!reset && running) begin
         eg  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
         can = !m_ov || out_ready;
         etr = (m_owner == 1) && can;
         ebr = (m_owner == 2) && can;
         chk("grant", grant, eg);
         chk("top_ready", top_ready, etr);
         chk("bot_ready", bot_ready, ebr);
         chk("out_valid", out_valid, m_ov);
         chk("out_data", out_data, m_od);
`ifdef STACK_ARB_COUNT_EN
         chk("top_pkt_count", top_pkt_count, CW'(m_tc));
         chk("bot_pkt_count", bot_pkt_count, CW'(m_bc));
`endif
         if (log_en) glog.push_back(grant);
         ta = top_valid && etr;
         ba = bot_valid && ebr;
         t_take = ta;
         b_take = ba;
         start_owner = m_owner;
         if (ta || ba) begin
            f = ta ? top_data : bot_data;
            exp_q.push_back(f);
            m_od = f;
            m_ov = 1'b1;
            if (f[FW-1]) begin
               if (ta) m_tc++;
               else m_bc++;
               m_last  = m_owner;
               m_owner = 0;
            end
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (start_owner == 0) begin
            if (top_valid && (!bot_valid || m_last == 2)) m_owner = 1;
            else if (bot_valid) m_owner = 2;
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [FW-1:0] e;
      if (!reset && running && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_flit actual=%0h required=<none queued>", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_flit", out_data, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (t_take && top_src.size() > 0) void'(top_src.pop_front());
      if (b_take && bot_src.size() > 0) void'(bot_src.pop_front());
      t_take = 1'b0;
      b_take = 1'b0;
      top_valid = (top_src.size() > 0) && ($urandom_range(99) < top_p);
      top_data  = (top_src.size() > 0) ? top_src[0] : '0;
      bot_valid = (bot_src.size() > 0) && ($urandom_range(99) < bot_p);
      bot_data  = (bot_src.size() > 0) ? bot_src[0] : '0;
      if (stall > 0) begin
         out_ready = 1'b0;
         stall--;
      end else begin
         out_ready = ($urandom_range(99) < ord_p);
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, "_rst_out_valid"}, out_valid, 0);
      chk({tag, "_rst_out_data"}, out_data, 0);
      chk({tag, "_rst_grant"}, grant, 0);
      chk({tag, "_rst_top_ready"}, top_ready, 0);
      chk({tag, "_rst_bot_ready"}, bot_ready, 0);
`ifdef STACK_ARB_COUNT_EN
      chk({tag, "_rst_top_cnt"}, top_pkt_count, 0);
      chk({tag, "_rst_bot_cnt"}, bot_pkt_count, 0);
`endif
      top_valid = 1'b0;
      bot_valid = 1'b0;
      out_ready = 1'b1;
      top_src.delete();
      bot_src.delete();
      exp_q.delete();
      m_owner = 0; m_last = 2; m_ov = 1'b0; m_od = '0; m_tc = 0; m_bc = 0;
      t_take = 1'b0; b_take = 1'b0; stall = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      running = 1'b1;
   endtask

   task automatic add_pkt(input bit bot, input int len);
      logic [FW-1:0] f;
      for (int i = 0; i < len; i++) begin
         f = FW'($urandom_range(0, 1023));
         f[FW-1] = (i == len - 1);
         if (bot) bot_src.push_back(f);
         else top_src.push_back(f);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((top_src.size() > 0 || bot_src.size() > 0 || exp_q.size() > 0 || stall > 0) && n < 4000) begin
         step();
         n++;
      end
      repeat (2) step();
      checks++;
      if (n >= 4000) begin
         failures++;
         $display("FAIL %s_drain actual=timeout required=drained", name);
      end
   endtask

   initial begin
      #2;
      // Simultaneous 3-flit packets: top first, one bubble, then bottom.
      do_reset("init");
      top_src.push_back(11'h001); top_src.push_back(11'h002); top_src.push_back(11'h403);
      bot_src.push_back(11'h011); bot_src.push_back(11'h012); bot_src.push_back(11'h413);
      glog.delete();
      step();
      log_en = 1'b1;
      repeat (7) step();
      @(negedge clk);
      #1 log_en = 1'b0;
      chk("grant_seq_len", glog.size(), 8);
      for (int i = 0; i < 8 && i < glog.size(); i++) chk($sformatf("grant_seq_%0d", i), glog[i], gexp[i]);
      drain("tie");

      // Back-to-back single-flit bottom packets.
      do_reset("single");
      bot_src.push_back(11'h4FC); bot_src.push_back(11'h4FD);
      drain("single");
`ifdef STACK_ARB_COUNT_EN
      chk("single_bot_count", bot_pkt_count, 2);
`endif

      // Top owns while bottom is held valid throughout.
      do_reset("hold");
      top_src.push_back(11'h001); top_src.push_back(11'h002); top_src.push_back(11'h403);
      add_pkt(1'b1, 3);
      drain("hold");

      // Downstream stall of 5 cycles mid-packet.
      do_reset("stall");
      add_pkt(1'b0, 5);
      repeat (3) step();
      stall = 5;
      drain("stall");

      // Reset mid-packet, then top regains priority.
      do_reset("pre_mid");
      add_pkt(1'b0, 3);
      repeat (3) step();
      #2;
      do_reset("mid");
      add_pkt(1'b0, 2);
      add_pkt(1'b1, 2);
      drain("post_mid");

`ifdef STACK_ARB_COUNT_EN
      do_reset("wrap");
      for (int i = 0; i < 17; i++) add_pkt(1'b0, 1);
      drain("wrap");
      chk("wrap_top_count", top_pkt_count, 1);
`endif

      // Random traffic with valid gaps and backpressure.
      do_reset("rand");
      top_p = 70; bot_p = 70; ord_p = 70;
      for (int i = 0; i < 30; i++) begin
         add_pkt(1'b0, $urandom_range(1, 4));
         add_pkt(1'b1, $urandom_range(1, 4));
      end
      drain("rand");
      ord_p = 100;
      drain("rand_tail");
      chk("rand_leftover", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
